// File: rtl/wavetable_voice_gen.sv
// wavetable_voice_gen: time-multiplexed polyphonic wavetable generator, one voice per cycle, mixed per sample_tick
module wavetable_voice_gen #(
  parameter int VOICES = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 6,
  parameter int PHASE_W = 16,
  parameter int OUT_W = DATA_W + $clog2(VOICES),
  localparam int VW = VOICES > 1 ? $clog2(VOICES) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sample_tick,
  input  logic [VOICES-1:0]  voice_en,
  input  logic [1:0]         wave_sel,
  input  logic               cfg_we,
  input  logic [VW-1:0]      cfg_voice,
  input  logic [PHASE_W-1:0] cfg_incr,
  output logic [OUT_W-1:0]   sample_out,
  output logic               sample_valid,
  output logic               busy,
  output logic               overrun
);
  localparam int M = 2 ** (DATA_W - 1);
  localparam int Q = 2 ** (ADDR_W - 2);
  localparam int SH = DATA_W - ADDR_W;
  function automatic logic [(Q+1)*DATA_W-1:0] gen_sine();
    logic [(Q+1)*DATA_W-1:0] tbl;
    tbl = '0;
    for (int n = 0; n <= Q; n++)
      tbl[n*DATA_W +: DATA_W] = DATA_W'(M + $rtoi((M - 1) * $sin(3.14159265358979 * n / (2.0 * Q)) + 0.5));
    return tbl;
  endfunction
  localparam logic [(Q+1)*DATA_W-1:0] SINE = gen_sine();
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t             state_q, state_d;
  logic [VW-1:0]      slot_q, slot_d;
  logic [OUT_W-1:0]   acc_q, acc_d, out_q, out_d;
  logic               ovr_q, ovr_d;
  logic [PHASE_W-1:0] phase_q [VOICES];
  logic [PHASE_W-1:0] phase_d [VOICES];
  logic [PHASE_W-1:0] incr_q [VOICES];
  logic [PHASE_W-1:0] incr_d [VOICES];
  logic [ADDR_W-1:0]  idx, tri_i;
  logic [1:0]         quad;
  logic [ADDR_W-2:0]  k;
  logic [DATA_W-1:0]  t, sine_v, tri_v, contrib;
  int                 tri_raw;
  // quarter-wave table mirrored in index (odd quadrants) and amplitude (lower half)
  always_comb begin
    idx = phase_q[slot_q][PHASE_W-1 -: ADDR_W];
    quad = idx[ADDR_W-1 -: 2];
    k = quad[0] ? (ADDR_W-1)'(Q) - {1'b0, idx[ADDR_W-3:0]} : {1'b0, idx[ADDR_W-3:0]};
    t = SINE[int'(k)*DATA_W +: DATA_W];
    sine_v = quad[1] ? DATA_W'(2 * M - int'(t)) : t;
    tri_i = idx[ADDR_W-1] ? ~idx : idx;
    tri_raw = (int'(tri_i) * 2) << SH;
    tri_v = tri_raw > 2 * M - 1 ? DATA_W'(2 * M - 1) : DATA_W'(tri_raw);
    contrib = !voice_en[slot_q] ? DATA_W'(M) :
              wave_sel == 2'd0 ? sine_v :
              wave_sel == 2'd1 ? (idx[ADDR_W-1] ? DATA_W'(1) : DATA_W'(2 * M - 1)) :
              wave_sel == 2'd2 ? DATA_W'(idx) << SH : tri_v;
  end
  always_comb begin
    state_d = state_q;
    slot_d = slot_q;
    acc_d = acc_q;
    out_d = out_q;
    phase_d = phase_q;
    incr_d = incr_q;
    ovr_d = sample_tick && state_q != IDLE;
    if (cfg_we && int'(cfg_voice) < VOICES) incr_d[cfg_voice] = cfg_incr;
    if (state_q == IDLE && sample_tick) begin
      state_d = RUN;
      slot_d = '0;
      acc_d = '0;
    end
    if (state_q == RUN) begin
      acc_d = acc_q + OUT_W'(contrib);
      phase_d[slot_q] = voice_en[slot_q] ? phase_q[slot_q] + incr_q[slot_q] : '0;
      slot_d = slot_q + 1'b1;
      if (int'(slot_q) == VOICES - 1) begin
        state_d = DONE;
        out_d = acc_q + OUT_W'(contrib);
      end
    end
    if (state_q == DONE) state_d = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      slot_q <= '0;
      acc_q <= '0;
      out_q <= '0;
      ovr_q <= 1'b0;
      phase_q <= '{default: '0};
      incr_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      slot_q <= slot_d;
      acc_q <= acc_d;
      out_q <= out_d;
      ovr_q <= ovr_d;
      phase_q <= phase_d;
      incr_q <= incr_d;
    end
  end
  assign sample_out = out_q;
  assign sample_valid = state_q == DONE;
  assign busy = state_q != IDLE;
  assign overrun = ovr_q;
endmodule

// File: doc/wavetable_voice_gen.md
# wavetable_voice_gen

Polyphonic wavetable tone generator for the piano audio path. It time-multiplexes VOICES phase accumulators over one shared quarter-wave sine table and waveform shaper, and sums all voices into one offset-binary sample per `sample_tick`. It sits between the key/frequency decoder, which writes per-voice phase increments, and the PWM/DAC output stage, which consumes `sample_out` on `sample_valid`.

## Interface
- `VOICES`, 4: number of voices (≥1).
- `ADDR_W`, 5: log2 of full-period table points (≥3).
- `DATA_W`, 6: per-voice sample width, offset binary (≥ADDR_W).
- `PHASE_W`, 16: phase accumulator width (≥ADDR_W).
- `OUT_W`, DATA_W+clog2(VOICES): mixed output width.

Ports:
- `clk` in 1: system clock, all logic on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `sample_tick` in 1: one-cycle request for a new output sample.
- `voice_en` in VOICES: per-voice enable (bit v = voice v).
- `wave_sel` in 2: 0 sine, 1 square, 2 sawtooth, 3 triangle (global).
- `cfg_we` in 1: write strobe for a phase increment.
- `cfg_voice` in clog2(VOICES): target voice of `cfg_we`.
- `cfg_incr` in PHASE_W: phase increment value.
- `sample_out` out OUT_W: registered mixed sample.
- `sample_valid` out 1: one-cycle strobe, `sample_out` updated.
- `busy` out 1: frame in progress.
- `overrun` out 1: one-cycle pulse, a `sample_tick` was dropped.

## Operation
- Per-voice state: `phase[v]` (PHASE_W), `incr[v]` (PHASE_W); both reset to 0.
- Index i = top ADDR_W bits of `phase[v]` before this frame's increment.
- Midscale M = 2^(DATA_W-1); Q = 2^(ADDR_W-2).
- Sine: quarter table T[0..Q], T[k] = M + round((M-1)·sin(πk/(2Q))). For defaults: 32,38,44,49,54,58,61,62,63. Quadrant q = i[ADDR_W-1:ADDR_W-2], j = low ADDR_W-2 bits.
  - q0 → T[j]; q1 → T[Q-j]; q2 → 2M-T[j]; q3 → 2M-T[Q-j].
  - Range 1..2M-1, symmetric about M.
  - The T list is generated per parameter set. Defaults are normative.
- Square: i < 2^(ADDR_W-1) → 2M-1, else 1.
- Sawtooth: i left-shifted by DATA_W-ADDR_W (0 at i=0, rising).
- Triangle: i < half → 2·i scaled; else (2^ADDR_W-1-i)·2 scaled. Scaling is a left shift by DATA_W-ADDR_W, saturated to 2M-1.
- Disabled voice:
  - contributes exactly M;
  - its phase is forced to 0 in its slot;
  - its incr is retained.
- Mix: unsigned sum of all VOICES contributions, no truncation. Max VOICES·(2M-1) fits OUT_W.
- FSM states:
  - IDLE: on `sample_tick` → RUN, slot v=0, accumulator cleared.
  - RUN: one voice per cycle. Look up and add the contribution, then `phase[v] += incr[v]` mod 2^PHASE_W. After slot VOICES-1 → DONE.
  - DONE: register the sum into `sample_out`, assert `sample_valid` → IDLE.
- `cfg_we` is accepted in every state; `incr[cfg_voice]` is written at the clock edge. If the write lands on voice v's RUN slot, that slot's phase update uses the old incr.
- `wave_sel` and `voice_en` are sampled per slot, not latched per frame.

## Timing
- Reset values: `sample_out` = 0, `sample_valid` = 0, `busy` = 0, `overrun` = 0, FSM = IDLE, all phase/incr = 0.
- Tick sampled at edge N:
  - `busy` = 1 from N+1 through N+VOICES+1.
  - `sample_valid` = 1 and `sample_out` valid in cycle N+VOICES+1.
  - Latency is VOICES+1 cycles.
- Next tick is accepted in the cycle after `sample_valid` (IDLE). Minimum tick period is VOICES+2.
- `sample_tick` while `busy` is dropped, and `overrun` pulses in the following cycle. The frame continues unaffected.
- `sample_out` holds between frames.
- `rst_n` low mid-frame clears all state immediately. No `sample_valid` is emitted for the aborted frame.

## Test plan
- Reset, then all voices disabled, tick → after 5 cycles `sample_valid`=1, `sample_out`=128 (4·32). `busy` high exactly 5 cycles.
- Voice 0 only, sine, incr=0x0800 (one table step/frame), others disabled → 32 frames give `sample_out` = 96 + {32,38,44,49,54,58,61,62,63,62,61,58,54,49,44,38,32,26,20,15,10,6,3,2,1,2,3,6,10,15,20,26}, then repeat.
- Square/sawtooth/triangle on voice 0, incr=0x0800 → contribution sequences are 63×16/1×16; 0,2,…,62; and the triangle ramp with saturation at 63.
- Tick again 2 cycles after an accepted tick → `overrun` one-cycle pulse. Only one `sample_valid`, with correct value.
- `cfg_we` to voice 2 during its RUN slot → that frame's phase advance uses the old incr, and the new incr applies from the next frame.
- `rst_n` low for 1 cycle mid-RUN → all outputs 0 asynchronously, no `sample_valid`. The next tick restarts from phase 0.
